// File: rtl/iecdrv_sd_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : iecdrv_sd_arbiter_if
// Brief    : Drive-side and host-side SD block bus of the IEC drive SD arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface iecdrv_sd_arbiter_if #(
    parameter int NDRV = 4
);
    logic [NDRV*32-1:0] drv_lba;
    logic [NDRV*6-1:0]  drv_blk_cnt;
    logic [NDRV-1:0]    drv_rd;
    logic [NDRV-1:0]    drv_wr;
    logic [NDRV-1:0]    drv_ack;
    logic [NDRV-1:0]    drv_buff_wr;
    logic [NDRV*8-1:0]  drv_buff_din;
    logic [31:0]        sd_lba;
    logic [5:0]         sd_blk_cnt;
    logic               sd_rd;
    logic               sd_wr;
    logic               sd_ack;
    logic               sd_buff_wr;
    logic [7:0]         sd_buff_din;
    logic [1:0]         grant;
    logic               busy;
    logic               wdog_to;

    // Arbiter side
    modport master (
        input  drv_lba, drv_blk_cnt, drv_rd, drv_wr, drv_buff_din, sd_ack, sd_buff_wr,
        output drv_ack, drv_buff_wr, sd_lba, sd_blk_cnt, sd_rd, sd_wr, sd_buff_din,
               grant, busy, wdog_to
    );

    // Drives plus host side
    modport slave (
        output drv_lba, drv_blk_cnt, drv_rd, drv_wr, drv_buff_din, sd_ack, sd_buff_wr,
        input  drv_ack, drv_buff_wr, sd_lba, sd_blk_cnt, sd_rd, sd_wr, sd_buff_din,
               grant, busy, wdog_to
    );
endinterface
`default_nettype wire

// File: rtl/iecdrv_sd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : iecdrv_sd_arbiter
// Brief    : Round-robin share of one SD block interface among NDRV IEC drives.
//            Optional REQ watchdog compiled in with IECDRV_SD_ARB_WDOG_EN.
// Revision : 1.0 - initial release
// ============================================================================
module iecdrv_sd_arbiter #(
    parameter int          NDRV        = 4,
    parameter logic [23:0] WDOG_CYCLES = 24'd8_000_000
) (
    input  wire logic           clk_sys,
    input  wire logic           reset_n,
    iecdrv_sd_arbiter_if.master bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] c_last_rst = 2'(NDRV - 1);

    state_t          r_state, w_state_nxt;
    logic [1:0]      r_grant, w_grant_nxt;
    logic [1:0]      r_last,  w_last_nxt;
    logic [31:0]     r_lba,   w_lba_nxt;
    logic [5:0]      r_blk,   w_blk_nxt;
    logic            r_rd,    w_rd_nxt;
    logic            r_wr,    w_wr_nxt;

    logic [NDRV-1:0] w_pending;
    logic            w_found;
    logic [1:0]      w_pick;
    logic [31:0]     w_sel_lba;
    logic [5:0]      w_sel_blk;
    logic            w_sel_rd;
    logic            w_sel_wr;
    logic            w_fwd;
    logic            w_wdog_expire;

    assign w_pending = bus.drv_rd | bus.drv_wr;

    // First pending drive scanning last+1, last+2, ... around the ring
    always_comb begin : p_pick
        int v_idx;
        w_found = 1'b0;
        w_pick  = 2'd0;
        v_idx   = 0;
        for (int k = 1; k <= NDRV; k++) begin
            v_idx = (int'(r_last) + k) % NDRV;
            if (!w_found && w_pending[v_idx]) begin
                w_found = 1'b1;
                w_pick  = v_idx[1:0];
            end
        end
    end

    always_comb begin : p_sel
        w_sel_lba = '0;
        w_sel_blk = '0;
        w_sel_rd  = 1'b0;
        w_sel_wr  = 1'b0;
        for (int i = 0; i < NDRV; i++) begin
            if (w_pick == 2'(i)) begin
                w_sel_lba = bus.drv_lba[i*32 +: 32];
                w_sel_blk = bus.drv_blk_cnt[i*6 +: 6];
                w_sel_rd  = bus.drv_rd[i];
                w_sel_wr  = bus.drv_wr[i];
            end
        end
    end

`ifdef IECDRV_SD_ARB_WDOG_EN
    logic [23:0] r_wdog_cnt;

    // Held at zero outside REQ, so every REQ entry starts from zero
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_wdog_cnt <= '0;
        end else if (r_state != REQ) begin
            r_wdog_cnt <= '0;
        end else begin
            r_wdog_cnt <= r_wdog_cnt + 24'd1;
        end
    end

    assign w_wdog_expire = (r_state == REQ) && !bus.sd_ack &&
                           (r_wdog_cnt == WDOG_CYCLES - 24'd1);
`else
    wire logic w_unused_wdog = &{1'b0, WDOG_CYCLES};
    assign w_wdog_expire = 1'b0;
`endif

    always_comb begin : p_next
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_last_nxt  = r_last;
        w_lba_nxt   = r_lba;
        w_blk_nxt   = r_blk;
        w_rd_nxt    = r_rd;
        w_wr_nxt    = r_wr;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt = REQ;
                    w_grant_nxt = w_pick;
                    w_lba_nxt   = w_sel_lba;
                    w_blk_nxt   = w_sel_blk;
                    w_wr_nxt    = w_sel_wr;
                    w_rd_nxt    = w_sel_rd & ~w_sel_wr;
                end
            end
            REQ: begin
                if (bus.sd_ack) begin
                    w_state_nxt = XFER;
                    w_rd_nxt    = 1'b0;
                    w_wr_nxt    = 1'b0;
                end else if (w_wdog_expire) begin
                    w_state_nxt = IDLE;
                    w_rd_nxt    = 1'b0;
                    w_wr_nxt    = 1'b0;
                    w_last_nxt  = r_grant;
                end
            end
            XFER: begin
                if (!bus.sd_ack) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_last_nxt  = r_grant;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_grant <= 2'd0;
            r_last  <= c_last_rst;
            r_lba   <= '0;
            r_blk   <= '0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_last  <= w_last_nxt;
            r_lba   <= w_lba_nxt;
            r_blk   <= w_blk_nxt;
            r_rd    <= w_rd_nxt;
            r_wr    <= w_wr_nxt;
        end
    end

    // Host strobes reach only the granted drive, and only while it owns the host
    assign w_fwd = (r_state == REQ) || (r_state == XFER);

    always_comb begin : p_route
        bus.drv_ack     = '0;
        bus.drv_buff_wr = '0;
        bus.sd_buff_din = '0;
        for (int i = 0; i < NDRV; i++) begin
            if (r_grant == 2'(i)) begin
                bus.drv_ack[i]     = w_fwd & bus.sd_ack;
                bus.drv_buff_wr[i] = w_fwd & bus.sd_buff_wr;
                bus.sd_buff_din    = bus.drv_buff_din[i*8 +: 8];
            end
        end
    end

    assign bus.sd_lba     = r_lba;
    assign bus.sd_blk_cnt = r_blk;
    assign bus.sd_rd      = r_rd;
    assign bus.sd_wr      = r_wr;
    assign bus.grant      = r_grant;
    assign bus.busy       = (r_state != IDLE);
    assign bus.wdog_to    = w_wdog_expire;

endmodule
`default_nettype wire

// File: tb/tb_iecdrv_sd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_iecdrv_sd_arbiter
// Brief    : Randomized self-checking bench with a transaction-level round-robin model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_iecdrv_sd_arbiter;
    localparam int          NDRV = 4;
    localparam logic [23:0] WDOG = 24'd16;

    logic clk_sys = 1'b0;
    logic reset_n = 1'b0;
    int   n_vec   = 0;
    int   n_err   = 0;

    // Model state: drive served most recently, plus what each drive presents
    logic [1:0]      m_last;
    logic [31:0]     m_lba [NDRV];
    logic [5:0]      m_blk [NDRV];
    logic [NDRV-1:0] m_rd;
    logic [NDRV-1:0] m_wr;

    iecdrv_sd_arbiter_if #(.NDRV(NDRV)) bus ();

    iecdrv_sd_arbiter #(.NDRV(NDRV), .WDOG_CYCLES(WDOG)) dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Winner is the pending drive at the smallest ring distance after the last one served
    function automatic int model_pick(input logic [NDRV-1:0] pend, input logic [1:0] last);
        int best, best_d, d;
        best   = -1;
        best_d = NDRV + 1;
        for (int i = 0; i < NDRV; i++) begin
            d = (i - int'(last) + NDRV - 1) % NDRV;
            if (pend[i] && d < best_d) begin
                best_d = d;
                best   = i;
            end
        end
        return best;
    endfunction

    function automatic logic [NDRV-1:0] onehot(input int idx);
        logic [NDRV-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk_sys);
        @(negedge clk_sys);
    endtask

    task automatic apply_drives();
        bus.drv_rd = m_rd;
        bus.drv_wr = m_wr;
        for (int i = 0; i < NDRV; i++) begin
            bus.drv_lba[i*32 +: 32]   = m_lba[i];
            bus.drv_blk_cnt[i*6 +: 6] = m_blk[i];
        end
    endtask

    task automatic clear_inputs();
        m_rd = '0;
        m_wr = '0;
        for (int i = 0; i < NDRV; i++) begin
            m_lba[i] = '0;
            m_blk[i] = '0;
        end
        apply_drives();
        bus.drv_buff_din = '0;
        bus.sd_ack       = 1'b0;
        bus.sd_buff_wr   = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset_n = 1'b0;
        tick();
        tick();
        n_vec++; if (bus.sd_rd !== 1'b0) begin n_err++; $display("FAIL reset_sd_rd: got %b want 0", bus.sd_rd); end
        n_vec++; if (bus.sd_wr !== 1'b0) begin n_err++; $display("FAIL reset_sd_wr: got %b want 0", bus.sd_wr); end
        n_vec++; if (bus.sd_lba !== 32'h0) begin n_err++; $display("FAIL reset_sd_lba: got %h want 0", bus.sd_lba); end
        n_vec++; if (bus.sd_blk_cnt !== 6'h0) begin n_err++; $display("FAIL reset_blk: got %h want 0", bus.sd_blk_cnt); end
        n_vec++; if (bus.grant !== 2'd0) begin n_err++; $display("FAIL reset_grant: got %0d want 0", bus.grant); end
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_vec++; if (bus.wdog_to !== 1'b0) begin n_err++; $display("FAIL reset_wdog: got %b want 0", bus.wdog_to); end
        reset_n = 1'b1;
        m_last  = 2'(NDRV - 1);
        bus.sd_ack = 1'b1;
        bus.sd_buff_wr = 1'b1;
        #1;
        n_vec++; if (bus.drv_ack !== '0) begin n_err++; $display("FAIL stray_ack: got %b want 0", bus.drv_ack); end
        n_vec++; if (bus.drv_buff_wr !== '0) begin n_err++; $display("FAIL stray_bwr: got %b want 0", bus.drv_buff_wr); end
        tick();
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL stray_busy: got %b want 0", bus.busy); end
        bus.sd_ack = 1'b0;
        bus.sd_buff_wr = 1'b0;
        tick();
    endtask

    task automatic test_single();
        int exp;
        m_rd = 4'b0001;
        m_lba[0] = 32'h100;
        m_blk[0] = 6'd3;
        apply_drives();
        exp = model_pick(m_rd, m_last);
        tick();
        n_vec++; if (bus.sd_rd !== 1'b1) begin n_err++; $display("FAIL single_rd: got %b want 1", bus.sd_rd); end
        n_vec++; if (bus.sd_lba !== 32'h100) begin n_err++; $display("FAIL single_lba: got %h want 100", bus.sd_lba); end
        n_vec++; if (bus.sd_blk_cnt !== 6'd3) begin n_err++; $display("FAIL single_blk: got %0d want 3", bus.sd_blk_cnt); end
        n_vec++; if (bus.grant !== 2'(exp)) begin n_err++; $display("FAIL single_grant: got %0d want %0d", bus.grant, exp); end
        bus.sd_ack = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            n_vec++; if (bus.drv_ack !== 4'b0001) begin n_err++; $display("FAIL single_ack c%0d: got %b want 0001", c, bus.drv_ack); end
            if (c == 0) begin
                m_rd = '0;
                apply_drives();
            end
            tick();
            n_vec++; if (bus.sd_rd !== 1'b0) begin n_err++; $display("FAIL single_rd_drop c%0d: got %b want 0", c, bus.sd_rd); end
        end
        bus.sd_ack = 1'b0;
        #1;
        n_vec++; if (bus.drv_ack !== 4'b0000) begin n_err++; $display("FAIL single_ack_fall: got %b want 0", bus.drv_ack); end
        tick();
        n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL single_busy_done: got %b want 1", bus.busy); end
        tick();
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL single_busy_idle: got %b want 0", bus.busy); end
        m_last = 2'(exp);
    endtask

    task automatic test_round_robin();
        int exp;
        int order [5];
        order = '{0, 1, 2, 3, 0};
        clear_inputs();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        m_last = 2'(NDRV - 1);
        m_rd = 4'b1111;
        for (int i = 0; i < NDRV; i++) begin
            m_lba[i] = $urandom();
            m_blk[i] = 6'($urandom_range(0, 63));
        end
        apply_drives();
        for (int t = 0; t < 5; t++) begin
            exp = model_pick(m_rd, m_last);
            tick();
            n_vec++; if (bus.grant !== 2'(exp) || exp != order[t]) begin n_err++; $display("FAIL rr_grant t%0d: got %0d want %0d", t, bus.grant, order[t]); end
            n_vec++; if (bus.sd_lba !== m_lba[exp]) begin n_err++; $display("FAIL rr_lba t%0d: got %h want %h", t, bus.sd_lba, m_lba[exp]); end
            n_vec++; if (bus.sd_rd !== 1'b1) begin n_err++; $display("FAIL rr_rd t%0d: got %b want 1", t, bus.sd_rd); end
            bus.sd_ack = 1'b1;
            #1;
            n_vec++; if (bus.drv_ack !== onehot(exp)) begin n_err++; $display("FAIL rr_ack t%0d: got %b want %b", t, bus.drv_ack, onehot(exp)); end
            tick();
            bus.sd_ack = 1'b0;
            tick();
            tick();
            m_last = 2'(exp);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_write_wins();
        int exp;
        logic [7:0] d;
        clear_inputs();
        m_rd[2] = 1'b1;
        m_wr[2] = 1'b1;
        m_lba[2] = $urandom();
        apply_drives();
        exp = model_pick(m_rd | m_wr, m_last);
        tick();
        n_vec++; if (bus.grant !== 2'(exp)) begin n_err++; $display("FAIL ww_grant: got %0d want %0d", bus.grant, exp); end
        n_vec++; if (bus.sd_wr !== 1'b1) begin n_err++; $display("FAIL ww_wr: got %b want 1", bus.sd_wr); end
        n_vec++; if (bus.sd_rd !== 1'b0) begin n_err++; $display("FAIL ww_rd: got %b want 0", bus.sd_rd); end
        bus.sd_ack = 1'b1;
        for (int c = 0; c < 8; c++) begin
            bus.drv_buff_din = $urandom();
            bus.sd_buff_wr   = 1'($urandom_range(0, 1));
            d = bus.drv_buff_din[23:16];
            #1;
            n_vec++; if (bus.sd_buff_din !== d) begin n_err++; $display("FAIL ww_din c%0d: got %h want %h", c, bus.sd_buff_din, d); end
            n_vec++; if (bus.drv_buff_wr !== (bus.sd_buff_wr ? 4'b0100 : 4'b0000)) begin n_err++; $display("FAIL ww_bwr c%0d: got %b sd_buff_wr %b", c, bus.drv_buff_wr, bus.sd_buff_wr); end
            if (c == 0) begin
                m_rd = '0;
                m_wr = '0;
                apply_drives();
            end
            tick();
        end
        bus.sd_ack = 1'b0;
        bus.sd_buff_wr = 1'b0;
        tick();
        tick();
        m_last = 2'(exp);
    endtask

    task automatic test_withdraw();
        int exp;
        logic [31:0] lba;
        clear_inputs();
        m_rd[1] = 1'b1;
        m_lba[1] = $urandom();
        lba = m_lba[1];
        apply_drives();
        exp = model_pick(m_rd, m_last);
        tick();
        n_vec++; if (bus.grant !== 2'(exp)) begin n_err++; $display("FAIL wd_grant: got %0d want %0d", bus.grant, exp); end
        m_rd = 4'b1000;
        m_lba[3] = $urandom();
        apply_drives();
        for (int c = 0; c < 4; c++) begin
            tick();
            n_vec++; if (bus.sd_rd !== 1'b1 || bus.sd_lba !== lba) begin n_err++; $display("FAIL wd_hold c%0d: got rd %b lba %h want 1 %h", c, bus.sd_rd, bus.sd_lba, lba); end
            n_vec++; if (bus.drv_ack !== 4'b0000) begin n_err++; $display("FAIL wd_noack c%0d: got %b want 0", c, bus.drv_ack); end
        end
        bus.sd_ack = 1'b1;
        #1;
        n_vec++; if (bus.drv_ack !== onehot(exp)) begin n_err++; $display("FAIL wd_ack: got %b want %b", bus.drv_ack, onehot(exp)); end
        tick();
        bus.sd_ack = 1'b0;
        tick();
        tick();
        m_last = 2'(exp);
        clear_inputs();
        tick();
    endtask

    task automatic test_watchdog();
        int exp;
        clear_inputs();
        m_rd = 4'b1001;
        apply_drives();
        exp = model_pick(m_rd, m_last);
        tick();
        n_vec++; if (bus.grant !== 2'(exp)) begin n_err++; $display("FAIL wdog_grant1: got %0d want %0d", bus.grant, exp); end
`ifdef IECDRV_SD_ARB_WDOG_EN
        for (int c = 1; c < 16; c++) begin
            #1;
            n_vec++; if (bus.wdog_to !== 1'b0) begin n_err++; $display("FAIL wdog_early c%0d: got %b want 0", c, bus.wdog_to); end
            tick();
        end
        #1;
        n_vec++; if (bus.wdog_to !== 1'b1) begin n_err++; $display("FAIL wdog_pulse: got %b want 1", bus.wdog_to); end
        tick();
        n_vec++; if (bus.sd_rd !== 1'b0 || bus.busy !== 1'b0 || bus.wdog_to !== 1'b0) begin n_err++; $display("FAIL wdog_drop: got rd %b busy %b to %b want 0 0 0", bus.sd_rd, bus.busy, bus.wdog_to); end
        m_last = 2'(exp);
        exp = model_pick(m_rd, m_last);
        tick();
        n_vec++; if (bus.grant !== 2'(exp) || bus.sd_rd !== 1'b1) begin n_err++; $display("FAIL wdog_regrant: got %0d rd %b want %0d 1", bus.grant, bus.sd_rd, exp); end
`else
        for (int c = 0; c < 24; c++) tick();
        n_vec++; if (bus.sd_rd !== 1'b1 || bus.wdog_to !== 1'b0) begin n_err++; $display("FAIL nowdog_wait: got rd %b to %b want 1 0", bus.sd_rd, bus.wdog_to); end
`endif
        bus.sd_ack = 1'b1;
        clear_inputs();
        bus.sd_ack = 1'b1;
        tick();
        bus.sd_ack = 1'b0;
        tick();
        tick();
        m_last = 2'(exp);
    endtask

    task automatic test_random();
        int exp, wait_c, ack_c;
        logic [NDRV-1:0] oh;
        logic [7:0] d;
        clear_inputs();
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < NDRV; i++) begin
                if (!(m_rd[i] | m_wr[i]) && $urandom_range(0, 1) == 1) begin
                    m_rd[i]  = 1'($urandom_range(0, 1));
                    m_wr[i]  = ~m_rd[i] | 1'($urandom_range(0, 1));
                    m_lba[i] = $urandom();
                    m_blk[i] = 6'($urandom_range(0, 63));
                end
            end
            if ((m_rd | m_wr) == '0) begin
                m_rd[it % NDRV]  = 1'b1;
                m_lba[it % NDRV] = $urandom();
            end
            apply_drives();
            exp = model_pick(m_rd | m_wr, m_last);
            oh  = onehot(exp);
            tick();
            n_vec++; if (bus.grant !== 2'(exp)) begin n_err++; $display("FAIL rnd_grant it%0d: got %0d want %0d", it, bus.grant, exp); end
            n_vec++; if (bus.sd_lba !== m_lba[exp] || bus.sd_blk_cnt !== m_blk[exp]) begin n_err++; $display("FAIL rnd_req it%0d: got %h/%0d want %h/%0d", it, bus.sd_lba, bus.sd_blk_cnt, m_lba[exp], m_blk[exp]); end
            n_vec++; if (bus.sd_wr !== m_wr[exp] || bus.sd_rd !== (m_rd[exp] & ~m_wr[exp])) begin n_err++; $display("FAIL rnd_rw it%0d: got rd %b wr %b want rd %b wr %b", it, bus.sd_rd, bus.sd_wr, m_rd[exp] & ~m_wr[exp], m_wr[exp]); end
            wait_c = $urandom_range(0, 3);
            for (int c = 0; c < wait_c; c++) begin
                tick();
                n_vec++; if (bus.drv_ack !== '0 || bus.busy !== 1'b1) begin n_err++; $display("FAIL rnd_wait it%0d: got ack %b busy %b want 0 1", it, bus.drv_ack, bus.busy); end
            end
            ack_c = $urandom_range(1, 4);
            bus.sd_ack = 1'b1;
            for (int c = 0; c < ack_c; c++) begin
                bus.sd_buff_wr   = 1'($urandom_range(0, 1));
                bus.drv_buff_din = $urandom();
                d = bus.drv_buff_din[exp*8 +: 8];
                #1;
                n_vec++; if (bus.drv_ack !== oh) begin n_err++; $display("FAIL rnd_ack it%0d: got %b want %b", it, bus.drv_ack, oh); end
                n_vec++; if (bus.drv_buff_wr !== (bus.sd_buff_wr ? oh : '0)) begin n_err++; $display("FAIL rnd_bwr it%0d: got %b want %b", it, bus.drv_buff_wr, bus.sd_buff_wr ? oh : '0); end
                n_vec++; if (bus.sd_buff_din !== d) begin n_err++; $display("FAIL rnd_din it%0d: got %h want %h", it, bus.sd_buff_din, d); end
                if (c == 0) begin
                    m_rd[exp] = 1'b0;
                    m_wr[exp] = 1'b0;
                    apply_drives();
                end
                tick();
            end
            bus.sd_ack     = 1'b0;
            bus.sd_buff_wr = 1'b0;
            #1;
            n_vec++; if (bus.drv_ack !== '0) begin n_err++; $display("FAIL rnd_ackfall it%0d: got %b want 0", it, bus.drv_ack); end
            tick();
            tick();
            n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rnd_idle it%0d: got %b want 0", it, bus.busy); end
            m_last = 2'(exp);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        int exp;
        clear_inputs();
        m_wr[2] = 1'b1;
        m_lba[2] = $urandom();
        apply_drives();
        exp = model_pick(m_wr, m_last);
        tick();
        n_vec++; if (bus.grant !== 2'(exp) || bus.sd_wr !== 1'b1) begin n_err++; $display("FAIL rm_grant: got %0d wr %b want %0d 1", bus.grant, bus.sd_wr, exp); end
        bus.sd_ack = 1'b1;
        tick();
        reset_n = 1'b0;
        tick();
        n_vec++; if (bus.sd_rd !== 1'b0 || bus.sd_wr !== 1'b0) begin n_err++; $display("FAIL rm_host: got rd %b wr %b want 0 0", bus.sd_rd, bus.sd_wr); end
        n_vec++; if (bus.drv_ack !== '0) begin n_err++; $display("FAIL rm_ack: got %b want 0", bus.drv_ack); end
        n_vec++; if (bus.busy !== 1'b0 || bus.grant !== 2'd0) begin n_err++; $display("FAIL rm_state: got busy %b grant %0d want 0 0", bus.busy, bus.grant); end
        reset_n = 1'b1;
        m_last  = 2'(NDRV - 1);
        clear_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_write_wins();
        test_withdraw();
        test_watchdog();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
